// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage owning the PC and the IF/ID register,
// with branch/jump/jr/exception redirect, stall hold and fetch-error flagging.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [25:0] id_imm26,
  input  logic [31:0] jr_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_target,
  output logic [31:0] pc,
  input  logic [31:0] ir,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_fetch_err
);
  localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * (IM_WORDS - 1));
  logic [31:0] pc_q, pc_d, id_ir_q, id_ir_d, id_pc_q, id_pc_d;
  logic        err_q, err_d;
  logic [31:0] pc4, id_pc4, br_tgt, j_tgt, npc;
  logic        fetch_err;
  assign pc4       = pc_q + 32'd4;
  assign id_pc4    = id_pc_q + 32'd4;
  assign br_tgt    = id_pc4 + {{14{id_imm26[15]}}, id_imm26[15:0], 2'b00};
  assign j_tgt     = {id_pc4[31:28], id_imm26, 2'b00};
  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
  assign npc = (npc_sel == 2'b01) ? (br_taken ? br_tgt : pc4) :
               (npc_sel == 2'b10) ? j_tgt :
               (npc_sel == 2'b11) ? jr_target : pc4;
  // exception redirect wins over stall and flushes IF/ID to a nop
  always_comb begin
    pc_d    = pc_q;
    id_ir_d = id_ir_q;
    id_pc_d = id_pc_q;
    err_d   = err_q;
    if (exc_redirect) begin
      pc_d    = exc_target;
      id_ir_d = '0;
      id_pc_d = '0;
      err_d   = 1'b0;
    end else if (!stall) begin
      pc_d    = npc;
      id_ir_d = fetch_err ? '0 : ir;
      id_pc_d = pc_q;
      err_d   = fetch_err;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      id_ir_q <= '0;
      id_pc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      id_ir_q <= id_ir_d;
      id_pc_q <= id_pc_d;
      err_q   <= err_d;
    end
  end
  assign pc           = pc_q;
  assign id_ir        = id_ir_q;
  assign id_pc        = id_pc_q;
  assign id_pc8       = id_pc_q + 32'd8;
  assign id_fetch_err = err_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random checks of fetch_stage against a behavioural model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, br_taken = 1'b0, exc_redirect = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [25:0] id_imm26 = '0;
  logic [31:0] jr_target = '0, exc_target = '0;
  logic [31:0] pc, ir, id_ir, id_pc, id_pc8;
  logic        id_fetch_err;
  int          total = 0, bad = 0;
  logic [31:0] m_pc, m_ir, m_idpc;
  logic        m_err;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .br_taken(br_taken),
    .id_imm26(id_imm26), .jr_target(jr_target), .exc_redirect(exc_redirect),
    .exc_target(exc_target), .pc(pc), .ir(ir), .id_ir(id_ir), .id_pc(id_pc),
    .id_pc8(id_pc8), .id_fetch_err(id_fetch_err)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign ir = tag(pc);

  function automatic logic bad_addr(input logic [31:0] a);
    longint unsigned x = longint'(a);
    return (x % 4 != 0) || (x < 64'h3000) || (x > 64'h3000 + 4 * 1023);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc", pc, m_pc);
    chk("id_ir", id_ir, m_ir);
    chk("id_pc", id_pc, m_idpc);
    chk("id_pc8", id_pc8, m_idpc + 32'd8);
    chk("id_fetch_err", {31'd0, id_fetch_err}, {31'd0, m_err});
  endtask

  // advance the model by one edge using the inputs currently applied, then check
  task automatic step();
    logic [31:0] seq, nxt, off;
    logic        e;
    seq = m_pc + 32'd4;
    off = 32'($signed(id_imm26[15:0])) * 32'd4;
    case (npc_sel)
      2'b01:   nxt = br_taken ? m_idpc + 32'd4 + off : seq;
      2'b10:   nxt = ((m_idpc + 32'd4) & 32'hF000_0000) + {4'd0, id_imm26, 2'b00};
      2'b11:   nxt = jr_target;
      default: nxt = seq;
    endcase
    if (reset) begin
      m_pc = 32'h3000; m_ir = 0; m_idpc = 0; m_err = 0;
    end else if (exc_redirect) begin
      m_pc = exc_target; m_ir = 0; m_idpc = 0; m_err = 0;
    end else if (!stall) begin
      e = bad_addr(m_pc);
      m_idpc = m_pc;
      m_ir = e ? 32'd0 : tag(m_pc);
      m_err = e;
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle();
    reset = 0; stall = 0; exc_redirect = 0; npc_sel = 2'b00; br_taken = 0;
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_idpc = 0; m_err = 0;
    #2;
    reset = 1; step();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc8", id_pc8, 32'd8);
    idle();
    for (int i = 0; i < 5; i++) step();
    chk("free_idpc", id_pc, 32'h3010);
    npc_sel = 2'b01; br_taken = 1; id_imm26 = 26'h000_FFFC; step();
    chk("br_taken_pc", pc, 32'h3004);
    chk("delay_slot", id_ir, tag(32'h3014));
    idle();
    reset = 1; step(); idle();
    for (int i = 0; i < 5; i++) step();
    npc_sel = 2'b01; br_taken = 0; step();
    chk("br_not_taken", pc, 32'h3018);
    idle();
    reset = 1; step(); idle(); step();
    npc_sel = 2'b10; id_imm26 = 26'h000_0C04; step();
    chk("jump_pc", pc, 32'h3010);
    npc_sel = 2'b11; jr_target = 32'h3020; step();
    chk("jr_pc", pc, 32'h3020);
    npc_sel = 2'b10; stall = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_pc", pc, 32'h3020);
    stall = 0; step();
    chk("post_stall_jump", pc, 32'h3010);
    npc_sel = 2'b00; stall = 1; exc_redirect = 1; exc_target = 32'h4180; step();
    chk("exc_pc", pc, 32'h4180);
    idle(); step();
    chk("exc_fetch_err", {31'd0, id_fetch_err}, 32'd1);
    chk("exc_idpc", id_pc, 32'h4180);
    npc_sel = 2'b11; jr_target = 32'h3002; step();
    idle(); step();
    chk("misalign_idpc", id_pc, 32'h3002);
    npc_sel = 2'b11; jr_target = 32'h3FFC; step();
    idle(); step();
    chk("last_word_ok", {31'd0, id_fetch_err}, 32'd0);
    step();
    chk("past_end_err", {31'd0, id_fetch_err}, 32'd1);
    npc_sel = 2'b11; jr_target = 32'hFFFF_FFFC; step();
    idle(); step();
    chk("wrap_pc", pc, 32'd0);
    step();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      exc_redirect = ($urandom_range(0, 15) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      npc_sel      = 2'($urandom_range(0, 3));
      br_taken     = 1'($urandom);
      id_imm26     = {16'($urandom_range(0, 3) * 16'h0400), 10'($urandom)};
      jr_target    = 32'h3000 + 32'($urandom_range(0, 1100)) * 4 + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      exc_target   = 32'h3000 + 32'($urandom_range(0, 1100)) * 4;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
